// File: rtl/miriscv_decode_stage.sv
// RISC-V decode stage: combinational field/immediate decode of the fetched word,
// buffered by an output register plus a skid register so f_ready_o is registered.
module miriscv_decode_stage #(
  parameter int unsigned ILLEGAL_CHECK = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_instr_i,
  input  logic [31:0] f_pc_i,
  output logic        f_ready_o,
  input  logic        flush_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [31:0] d_instr_o,
  output logic [31:0] d_pc_o,
  output logic [4:0]  d_opcode_o,
  output logic [4:0]  d_rd_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [2:0]  d_funct3_o,
  output logic [31:0] d_imm_o,
  output logic        d_illegal_o
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        illegal;
  } entry_t;

  entry_t      dec;
  entry_t      out_q;
  entry_t      skid_q;
  logic        out_valid;
  logic        skid_valid;
  logic        known_opcode;
  logic        bad_funct;
  logic        enc_illegal;
  logic [31:0] imm_raw;
  logic [31:0] instr;
  logic [2:0]  funct3;
  logic        in_fire;
  logic        out_fire;

  assign instr  = f_instr_i;
  assign funct3 = f_instr_i[14:12];

  always_comb begin
    imm_raw      = '0;
    known_opcode = 1'b1;
    bad_funct    = 1'b0;
    case (instr[6:2])
      OPC_OPIMM: imm_raw = {{20{instr[31]}}, instr[31:20]};
      OPC_LOAD: begin
        imm_raw   = {{20{instr[31]}}, instr[31:20]};
        bad_funct = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_JALR: begin
        imm_raw   = {{20{instr[31]}}, instr[31:20]};
        bad_funct = (funct3 != 3'b000);
      end
      OPC_STORE: begin
        imm_raw   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        bad_funct = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        imm_raw   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        bad_funct = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: imm_raw = {instr[31:12], 12'b0};
      OPC_JAL: imm_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_OP, OPC_FENCE, OPC_SYSTEM: imm_raw = '0;
      default: known_opcode = 1'b0;
    endcase
  end

  // The immediate is zeroed for malformed encodings even when reporting is disabled.
  assign enc_illegal = (instr[1:0] != 2'b11) || !known_opcode || bad_funct;

  always_comb begin
    dec         = '0;
    dec.instr   = f_instr_i;
    dec.pc      = f_pc_i;
    dec.opcode  = instr[6:2];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct3  = funct3;
    dec.imm     = enc_illegal ? 32'd0 : imm_raw;
    dec.illegal = (ILLEGAL_CHECK != 0) && enc_illegal;
  end

  assign in_fire  = f_valid_i && !skid_valid;
  assign out_fire = out_valid && d_ready_i;

  // When SKID is full f_ready_o is low, so a drain refills OUT from SKID only.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_fire && skid_valid) begin
      out_q      <= skid_q;
      skid_valid <= 1'b0;
    end else if (in_fire && (!out_valid || out_fire)) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign f_ready_o   = !skid_valid;
  assign d_valid_o   = out_valid;
  assign d_instr_o   = out_q.instr;
  assign d_pc_o      = out_q.pc;
  assign d_opcode_o  = out_q.opcode;
  assign d_rd_o      = out_q.rd;
  assign d_rs1_o     = out_q.rs1;
  assign d_rs2_o     = out_q.rs2;
  assign d_funct3_o  = out_q.funct3;
  assign d_imm_o     = out_q.imm;
  assign d_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Scoreboard bench for miriscv_decode_stage: directed instruction words with
// hand-decoded expectations, checked by a monitor on every output handshake.
module tb_miriscv_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_ready_o;
  logic        flush;
  logic        d_valid_o;
  logic        d_ready;
  logic [31:0] d_instr_o;
  logic [31:0] d_pc_o;
  logic [4:0]  d_opcode_o;
  logic [4:0]  d_rd_o;
  logic [4:0]  d_rs1_o;
  logic [4:0]  d_rs2_o;
  logic [2:0]  d_funct3_o;
  logic [31:0] d_imm_o;
  logic        d_illegal_o;

  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];
  exp_t mon_exp;

  miriscv_decode_stage #(.ILLEGAL_CHECK(1)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .f_valid_i(f_valid),
    .f_instr_i(f_instr),
    .f_pc_i(f_pc),
    .f_ready_o(f_ready_o),
    .flush_i(flush),
    .d_valid_o(d_valid_o),
    .d_ready_i(d_ready),
    .d_instr_o(d_instr_o),
    .d_pc_o(d_pc_o),
    .d_opcode_o(d_opcode_o),
    .d_rd_o(d_rd_o),
    .d_rs1_o(d_rs1_o),
    .d_rs2_o(d_rs2_o),
    .d_funct3_o(d_funct3_o),
    .d_imm_o(d_imm_o),
    .d_illegal_o(d_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [31:0] imm, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.opcode = op; e.rd = rd; e.rs1 = rs1;
    e.rs2 = rs2; e.funct3 = f3; e.imm = imm; e.illegal = ill;
    return e;
  endfunction

  // Drives one instruction and records its expectation on the edge it is accepted.
  task automatic applyStimulus(input exp_t e);
    bit accepted;
    accepted = 1'b0;
    f_valid  = 1'b1;
    f_instr  = e.instr;
    f_pc     = e.pc;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      if (f_ready_o) accepted = 1'b1;
    end
    if (accepted) sb.push_back(e);
    else begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got f_ready_o=0 for 20 cycles, want 1 (instr 0x%08h)", e.instr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && d_valid_o && d_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got instr 0x%08h, want no output", d_instr_o);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("instr", d_instr_o, mon_exp.instr);
        checkOutput("pc", d_pc_o, mon_exp.pc);
        checkOutput("opcode", {27'd0, d_opcode_o}, {27'd0, mon_exp.opcode});
        checkOutput("rd", {27'd0, d_rd_o}, {27'd0, mon_exp.rd});
        checkOutput("rs1", {27'd0, d_rs1_o}, {27'd0, mon_exp.rs1});
        checkOutput("rs2", {27'd0, d_rs2_o}, {27'd0, mon_exp.rs2});
        checkOutput("funct3", {29'd0, d_funct3_o}, {29'd0, mon_exp.funct3});
        checkOutput("imm", d_imm_o, mon_exp.imm);
        checkOutput("illegal", {31'd0, d_illegal_o}, {31'd0, mon_exp.illegal});
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion, want $finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t v_addi, v_beq, v_zero, v_jalr_bad, v_lui, v_sw, v_jal, v_ld_bad;
    exp_t v_br_bad, v_st_bad, v_undef, v_lw_neg, v_sw_neg, v_auipc, v_add;
    int c0;

    v_addi     = mk(32'h00500093, 32'h00001000, 5'b00100, 5'd1,  5'd0,  5'd5,  3'd0, 32'h00000005, 1'b0);
    v_beq      = mk(32'hFE000EE3, 32'h00001004, 5'b11000, 5'd29, 5'd0,  5'd0,  3'd0, 32'hFFFFFFFC, 1'b0);
    v_zero     = mk(32'h00000000, 32'h00001008, 5'b00000, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000000, 1'b1);
    v_jalr_bad = mk(32'h00003067, 32'h0000100C, 5'b11001, 5'd0,  5'd0,  5'd0,  3'd3, 32'h00000000, 1'b1);
    v_lui      = mk(32'h12345137, 32'h00001010, 5'b01101, 5'd2,  5'd8,  5'd3,  3'd5, 32'h12345000, 1'b0);
    v_sw       = mk(32'h00512423, 32'h00001014, 5'b01000, 5'd8,  5'd2,  5'd5,  3'd2, 32'h00000008, 1'b0);
    v_jal      = mk(32'h008000EF, 32'h00001018, 5'b11011, 5'd1,  5'd0,  5'd8,  3'd0, 32'h00000008, 1'b0);
    v_ld_bad   = mk(32'h00003003, 32'h0000101C, 5'b00000, 5'd0,  5'd0,  5'd0,  3'd3, 32'h00000000, 1'b1);
    v_br_bad   = mk(32'h00002063, 32'h00001020, 5'b11000, 5'd0,  5'd0,  5'd0,  3'd2, 32'h00000000, 1'b1);
    v_st_bad   = mk(32'h00003023, 32'h00001024, 5'b01000, 5'd0,  5'd0,  5'd0,  3'd3, 32'h00000000, 1'b1);
    v_undef    = mk(32'h0000007F, 32'h00001028, 5'b11111, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000000, 1'b1);
    v_lw_neg   = mk(32'hFF80A183, 32'h0000102C, 5'b00000, 5'd3,  5'd1,  5'd24, 3'd2, 32'hFFFFFFF8, 1'b0);
    v_sw_neg   = mk(32'hFE512E23, 32'h00001030, 5'b01000, 5'd28, 5'd2,  5'd5,  3'd2, 32'hFFFFFFFC, 1'b0);
    v_auipc    = mk(32'hFFFFF097, 32'h00001034, 5'b00101, 5'd1,  5'd31, 5'd31, 3'd7, 32'hFFFFF000, 1'b0);
    v_add      = mk(32'h002081B3, 32'h00001038, 5'b01100, 5'd3,  5'd1,  5'd2,  3'd0, 32'h00000000, 1'b0);

    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; f_valid = 1'b0; f_instr = '0; f_pc = '0; flush = 1'b0; d_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_d_valid", {31'd0, d_valid_o}, 32'd0);
    checkOutput("reset_f_ready", {31'd0, f_ready_o}, 32'd1);
    checkOutput("reset_d_instr", d_instr_o, 32'd0);
    checkOutput("reset_d_imm", d_imm_o, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] single addi, one-cycle latency");
    d_ready = 1'b1;
    applyStimulus(v_addi);
    f_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_d_valid", {31'd0, d_valid_o}, 32'd1);
    checkOutput("latency_d_instr", d_instr_o, v_addi.instr);
    @(posedge clk);
    #1;
    waitDrain("drain_addi");

    $display("[TB] back-to-back decode burst");
    c0 = cyc;
    applyStimulus(v_beq);
    applyStimulus(v_zero);
    applyStimulus(v_jalr_bad);
    applyStimulus(v_lui);
    applyStimulus(v_sw);
    applyStimulus(v_jal);
    applyStimulus(v_ld_bad);
    applyStimulus(v_br_bad);
    applyStimulus(v_st_bad);
    applyStimulus(v_undef);
    applyStimulus(v_lw_neg);
    applyStimulus(v_sw_neg);
    applyStimulus(v_auipc);
    applyStimulus(v_add);
    checkOutput("burst_cycles", cyc - c0, 32'd14);
    f_valid = 1'b0;
    waitDrain("drain_burst");

    $display("[TB] stall with skid, then release");
    d_ready = 1'b0;
    applyStimulus(v_addi);
    applyStimulus(v_sw);
    f_valid = 1'b1;
    f_instr = v_jal.instr;
    f_pc    = v_jal.pc;
    @(negedge clk);
    checkOutput("stall_f_ready", {31'd0, f_ready_o}, 32'd0);
    checkOutput("stall_d_valid", {31'd0, d_valid_o}, 32'd1);
    checkOutput("stall_hold_a", d_instr_o, v_addi.instr);
    @(posedge clk);
    #1 d_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_a", d_instr_o, v_addi.instr);
    checkOutput("release_f_ready_a", {31'd0, f_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release_b", d_instr_o, v_sw.instr);
    checkOutput("release_f_ready_b", {31'd0, f_ready_o}, 32'd1);
    sb.push_back(v_jal);
    @(posedge clk);
    #1 f_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_c_valid", {31'd0, d_valid_o}, 32'd1);
    checkOutput("release_c", d_instr_o, v_jal.instr);
    @(posedge clk);
    #1;
    waitDrain("drain_stall");

    $display("[TB] flush with both entries full");
    d_ready = 1'b0;
    applyStimulus(v_add);
    applyStimulus(v_lui);
    f_valid = 1'b1;
    f_instr = v_jal.instr;
    f_pc    = v_jal.pc;
    flush   = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    f_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("flush_full_d_valid", {31'd0, d_valid_o}, 32'd0);
    checkOutput("flush_full_f_ready", {31'd0, f_ready_o}, 32'd1);

    $display("[TB] flush with OUT full and input offered");
    @(posedge clk);
    #1;
    applyStimulus(v_add);
    f_instr = v_beq.instr;
    f_pc    = v_beq.pc;
    flush   = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    f_valid = 1'b0;
    sb.delete();
    d_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_d_valid", {31'd0, d_valid_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("flush_in_not_captured", {31'd0, d_valid_o}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-stall");
    d_ready = 1'b0;
    applyStimulus(v_auipc);
    applyStimulus(v_lw_neg);
    f_valid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("rst_d_valid", {31'd0, d_valid_o}, 32'd0);
    checkOutput("rst_d_pc", d_pc_o, 32'd0);
    checkOutput("rst_f_ready", {31'd0, f_ready_o}, 32'd1);
    checkOutput("rst_d_instr", d_instr_o, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] recovery after reset");
    d_ready = 1'b1;
    applyStimulus(v_beq);
    f_valid = 1'b0;
    waitDrain("drain_recovery");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_decode_stage.md
MIRISCV_DECODE_STAGE -- requirements
Module: miriscv_decode_stage

Interface
REQ-001 SHALL have parameter ILLEGAL_CHECK, default 1: 1 enables illegal-instruction detection; 0 forces d_illegal_o to 0.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port f_valid_i, input, 1 bit: the fetch stage presents an instruction.
REQ-005 SHALL have port f_instr_i, input, 32 bits: the fetched instruction word.
REQ-006 SHALL have port f_pc_i, input, 32 bits: the PC of f_instr_i.
REQ-007 SHALL have port f_ready_o, output, 1 bit: the stage accepts an input this cycle.
REQ-008 SHALL have port flush_i, input, 1 bit: discard all held and incoming instructions.
REQ-009 SHALL have port d_valid_o, output, 1 bit: decoded instruction valid.
REQ-010 SHALL have port d_ready_i, input, 1 bit: the execute stage accepts the output.
REQ-011 SHALL have ports d_instr_o and d_pc_o, output, 32 bits each: the instruction word and PC passed through unchanged.
REQ-012 SHALL have port d_opcode_o, output, 5 bits: instr[6:2], encoded per the short-opcode constants of the core opcode package.
REQ-013 SHALL have ports d_rd_o, d_rs1_o and d_rs2_o, output, 5 bits each: instr[11:7], instr[19:15] and instr[24:20].
REQ-014 SHALL have port d_funct3_o, output, 3 bits: instr[14:12].
REQ-015 SHALL have port d_imm_o, output, 32 bits: the sign-extended immediate.
REQ-016 SHALL have port d_illegal_o, output, 1 bit: the instruction is illegal.

Function
REQ-017 SHALL hold two entries: an output register (OUT) and a skid register (SKID), each with its own valid bit.
REQ-018 SHALL perform decode combinationally on the f_* inputs and store the decoded fields into the entry that captures them.
REQ-019 SHALL drive f_ready_o = !SKID.valid, taken from a register, so f_ready_o has no combinational path from d_ready_i.
REQ-020 SHALL define the input handshake as f_valid_i & f_ready_o, and the output handshake as d_valid_o & d_ready_i.
REQ-021 SHALL resolve the input transfer as follows, on the edge of the transfer cycle:
- OUT empty, or OUT draining with SKID empty: the input loads into OUT.
- OUT full and not draining: the input loads into SKID.
REQ-022 SHALL, when OUT drains while SKID is full, move SKID into OUT and clear SKID on the same edge; f_ready_o is low that cycle, so no input is taken.
REQ-023 SHALL deliver instructions strictly in order, with no loss and no duplication, and with one-cycle latency from input transfer to d_valid_o when unstalled.
REQ-024 SHALL sustain one instruction per cycle when d_ready_i is held at 1.
REQ-025 SHALL select the immediate by opcode:
- I-type for OPIMM, LOAD and JALR.
- S-type for STORE.
- B-type for BRANCH (bit0 = 0).
- U-type for LUI and AUIPC ({instr[31:12], 12'b0}).
- J-type for JAL (bit0 = 0).
- 0 for OP, FENCE, SYSTEM and illegal encodings.
REQ-026 SHALL, when ILLEGAL_CHECK = 1, flag an instruction illegal if any of the following holds:
- instr[1:0] != 2'b11.
- The opcode is not one of the 11 defined opcodes.
- JALR with funct3 != 000.
- BRANCH with funct3 = 010 or 011.
- LOAD with funct3 = 011, 110 or 111.
- STORE with funct3 > 010.
REQ-027 SHALL still propagate an illegal instruction as valid, with d_illegal_o = 1; the stage never stalls on an illegal instruction.
REQ-028 SHALL, on flush_i = 1, clear both valid bits at the edge and take no input that cycle (f_ready_o = 1 from the following cycle); flush_i has priority over every transfer.

Reset
REQ-029 SHALL, while rst_n_i = 0 at a rising edge, clear OUT.valid and SKID.valid and zero all stored fields; the following cycle d_valid_o = 0, f_ready_o = 1 and all d_* data outputs read 0.
REQ-030 SHALL let a reset asserted mid-stall discard both entries, with no output handshake occurring in the reset cycle.

Verification
REQ-031 SHALL be verified by the following directed scenarios:
- 0x00500093 (addi x1,x0,5) with d_ready_i = 1 -> next cycle d_valid_o = 1, d_opcode_o = 00100, d_rd_o = 1, d_imm_o = 5, d_illegal_o = 0.
- 0xFE000EE3 (beq x0,x0,-4) -> d_opcode_o = 11000, d_imm_o = 0xFFFFFFFC.
- 0x00000000, then 0x00003067 (jalr with funct3 = 011) -> both d_illegal_o = 1, d_imm_o = 0.
- d_ready_i = 0; inputs A, B, C offered back-to-back -> A in OUT, B in SKID, f_ready_o = 0 and C held; raise d_ready_i -> outputs A, B, C on consecutive cycles.
- Both entries full; flush_i for 1 cycle -> next cycle d_valid_o = 0, f_ready_o = 1; the flush-cycle input is not captured.
- rst_n_i = 0 for 1 cycle with both entries full -> d_valid_o = 0, d_pc_o = 0, f_ready_o = 1 on the next cycle.
